arcade_input_ctrl: RTL and testbench

Parametrised input and configuration front-end for arcade cores: decodes PS/2 key events into per-player key state and merges them with joystick words. It adds coin pulse shaping, optional autofire and a latched pause toggle, and captures DIP-switch and game-index downloads from the ioctl stream. It sits between `hps_io` and the game core inside `emu`, replacing the hand-written key decode and DIP capture logic.

---
 rtl/arcade_input_pkg.sv | 36 +++
 rtl/arcade_input_ctrl_coin.sv | 61 ++++++
 rtl/arcade_input_ctrl.sv | 144 ++++++++++++++
 tb/tb_arcade_input_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/arcade_input_pkg.sv
// Shared definitions for the arcade input front-end: per-player bit map,
// default PS/2 key assignment table and coin shaper state encoding.
package arcade_input_pkg;

    localparam int BIT_RIGHT = 0;
    localparam int BIT_LEFT  = 1;
    localparam int BIT_DOWN  = 2;
    localparam int BIT_UP    = 3;
    localparam int BIT_B1    = 4;
    localparam int BIT_B2    = 5;
    localparam int BIT_B3    = 6;
    localparam int BIT_START = 7;
    localparam int BIT_COIN  = 8;
    localparam int BIT_PAUSE = 9;
    localparam int NUM_BITS  = 10;

    typedef enum logic [1:0] {
        CS_IDLE,
        CS_PULSE,
        CS_WAIT_REL
    } coin_state_t;

    // {extended, scancode} per player and bit; 9'h000 leaves the bit unmapped.
    // 'P' (9'h04D) is shared so one key pauses from any player's map.
    localparam logic [8:0] KEYMAP [4][10] = '{
        '{9'h174, 9'h16B, 9'h172, 9'h175, 9'h014, 9'h011, 9'h029, 9'h016, 9'h02E, 9'h04D},
        '{9'h034, 9'h023, 9'h02B, 9'h02D, 9'h01C, 9'h01B, 9'h015, 9'h01E, 9'h036, 9'h04D},
        '{9'h04B, 9'h03B, 9'h042, 9'h043, 9'h114, 9'h059, 9'h05A, 9'h026, 9'h03D, 9'h04D},
        '{9'h074, 9'h06B, 9'h072, 9'h075, 9'h070, 9'h071, 9'h15A, 9'h025, 9'h03E, 9'h04D}
    };

    function automatic logic key_match(input logic [8:0] entry, input logic [8:0] event_code);
        return (entry != 9'h000) && (entry == event_code);
    endfunction

endpackage

// File: rtl/arcade_input_ctrl_coin.sv
// Coin pulse shaper: a rising coin request yields exactly COIN_PULSE cycles
// of output, then waits for the request to be released before re-arming.
module coin_shaper
    import arcade_input_pkg::*;
#(
    parameter int COIN_PULSE = 1_600_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic coin_i,
    output logic coin_o
);

    localparam int CW = (COIN_PULSE > 1) ? $clog2(COIN_PULSE) : 1;

    coin_state_t   state_q;
    logic [CW-1:0] cnt_q;
    logic          prev_q;
    logic          coin_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= CS_IDLE;
            cnt_q   <= '0;
            prev_q  <= 1'b0;
            coin_q  <= 1'b0;
        end else begin
            prev_q <= coin_i;
            case (state_q)
                CS_IDLE: begin
                    if (coin_i && !prev_q) begin
                        cnt_q   <= CW'(COIN_PULSE - 1);
                        coin_q  <= 1'b1;
                        state_q <= CS_PULSE;
                    end
                end
                CS_PULSE: begin
                    // Further presses while the pulse runs are deliberately ignored.
                    if (cnt_q == '0) begin
                        coin_q  <= 1'b0;
                        state_q <= CS_WAIT_REL;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                CS_WAIT_REL: begin
                    if (!coin_i) begin
                        state_q <= CS_IDLE;
                    end
                end
                default: begin
                    coin_q  <= 1'b0;
                    state_q <= CS_IDLE;
                end
            endcase
        end
    end

    assign coin_o = coin_q;

endmodule

// File: rtl/arcade_input_ctrl.sv
// Arcade input front-end: PS/2 key decode merged with joysticks, coin shaping,
// autofire, pause toggle and DIP / game-index capture from the ioctl stream.
module arcade_input_ctrl
    import arcade_input_pkg::*;
#(
    parameter int NUM_PLAYERS  = 2,
    parameter int NUM_DIPS     = 8,
    parameter int DIP_INDEX    = 254,
    parameter int GAME_INDEX   = 1,
    parameter int COIN_PULSE   = 1_600_000,
    parameter int AUTOFIRE_DIV = 3_200_000
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [10:0]              ps2_key,
    input  logic [NUM_PLAYERS*32-1:0] joystick,
    input  logic [NUM_PLAYERS-1:0]   autofire_en,
    input  logic                     ioctl_wr,
    input  logic [15:0]              ioctl_index,
    input  logic [26:0]              ioctl_addr,
    input  logic [7:0]               ioctl_data,
    output logic [NUM_PLAYERS*4-1:0] dir,
    output logic [NUM_PLAYERS*3-1:0] btn,
    output logic [NUM_PLAYERS-1:0]   start,
    output logic [NUM_PLAYERS-1:0]   coin,
    output logic                     pause,
    output logic [NUM_DIPS*8-1:0]    dip,
    output logic [3:0]               game_index
);

    localparam int AW = $clog2(AUTOFIRE_DIV + 1);

    logic                                   tog_q;
    logic [NUM_PLAYERS-1:0][NUM_BITS-1:0]   key_q, key_d;
    logic [NUM_PLAYERS-1:0][NUM_BITS-1:0]   merged;
    logic [NUM_PLAYERS-1:0][3:0]            dir_q, dir_d;
    logic [NUM_PLAYERS-1:0][2:0]            btn_q, btn_d;
    logic [NUM_PLAYERS-1:0]                 start_q, start_d;
    logic                                   pause_q, pause_prev_q, pause_any;
    logic [AW-1:0]                          div_q;
    logic                                   phase_q;
    logic [NUM_DIPS-1:0][7:0]               dip_q;
    logic [3:0]                             game_q;
    logic                                   dip_wr, game_wr;
    logic                                   unused_bits;

    // A toggle of ps2_key[10] marks a new event; every matching map entry follows it.
    always_comb begin
        key_d = key_q;
        if (ps2_key[10] != tog_q) begin
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                for (int b = 0; b < NUM_BITS; b++) begin
                    if (key_match(KEYMAP[p][b], ps2_key[8:0])) begin
                        key_d[p][b] = ps2_key[9];
                    end
                end
            end
        end
    end

    always_comb begin
        pause_any = 1'b0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            merged[p]  = key_q[p] | joystick[32*p +: NUM_BITS];
            dir_d[p]   = {merged[p][BIT_UP], merged[p][BIT_DOWN],
                          merged[p][BIT_RIGHT], merged[p][BIT_LEFT]};
            btn_d[p]   = {merged[p][BIT_B3], merged[p][BIT_B2],
                          merged[p][BIT_B1] & (~autofire_en[p] | phase_q)};
            start_d[p] = merged[p][BIT_START];
            pause_any  = pause_any | merged[p][BIT_PAUSE];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tog_q        <= 1'b0;
            key_q        <= '0;
            dir_q        <= '0;
            btn_q        <= '0;
            start_q      <= '0;
            pause_q      <= 1'b0;
            pause_prev_q <= 1'b0;
            div_q        <= '0;
            phase_q      <= 1'b0;
        end else begin
            tog_q        <= ps2_key[10];
            key_q        <= key_d;
            dir_q        <= dir_d;
            btn_q        <= btn_d;
            start_q      <= start_d;
            pause_prev_q <= pause_any;
            if (pause_any && !pause_prev_q) begin
                pause_q <= ~pause_q;
            end
            // Shared autofire divider: phase flips once per AUTOFIRE_DIV cycles.
            if (div_q == AW'(AUTOFIRE_DIV - 1)) begin
                div_q   <= '0;
                phase_q <= ~phase_q;
            end else begin
                div_q <= div_q + 1'b1;
            end
        end
    end

    assign dip_wr  = ioctl_wr && (ioctl_index == 16'(DIP_INDEX));
    assign game_wr = ioctl_wr && (ioctl_index == 16'(GAME_INDEX));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dip_q  <= '0;
            game_q <= '0;
        end else begin
            // Addresses at or beyond NUM_DIPS match no slot and are dropped.
            for (int i = 0; i < NUM_DIPS; i++) begin
                if (dip_wr && (ioctl_addr == 27'(i))) begin
                    dip_q[i] <= ioctl_data;
                end
            end
            if (game_wr) begin
                game_q <= ioctl_data[3:0];
            end
        end
    end

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_coin
        coin_shaper #(
            .COIN_PULSE(COIN_PULSE)
        ) u_coin (
            .clk    (clk),
            .reset_n(reset_n),
            .coin_i (merged[p][BIT_COIN]),
            .coin_o (coin[p])
        );
    end

    assign dir         = dir_q;
    assign btn         = btn_q;
    assign start       = start_q;
    assign pause       = pause_q;
    assign dip         = dip_q;
    assign game_index  = game_q;
    assign unused_bits = ^joystick;

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Directed and randomized stimulus for arcade_input_ctrl, checked against an
// event-level reference model of keys, coin pulses, autofire, pause and ioctl.
module tb_arcade_input_ctrl;
    import arcade_input_pkg::*;

    localparam int NP = 2;
    localparam int CP = 4;
    localparam int AD = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [10:0] ps2_key = '0;
    logic [63:0] joystick = '0;
    logic [1:0]  autofire_en = '0;
    logic        ioctl_wr = 1'b0;
    logic [15:0] ioctl_index = '0;
    logic [26:0] ioctl_addr = '0;
    logic [7:0]  ioctl_data = '0;
    logic [7:0]  dir;
    logic [5:0]  btn;
    logic [1:0]  start;
    logic [1:0]  coin;
    logic        pause;
    logic [63:0] dip;
    logic [3:0]  game_index;

    int checks = 0;
    int failures = 0;

    // reference model state
    logic [1:0][9:0] m_key;
    logic            m_tog;
    int              m_cyc;
    int              m_hi [2];
    logic [1:0]      m_wait, m_cprev;
    logic            m_pprev;
    logic [7:0]      exp_dir;
    logic [5:0]      exp_btn;
    logic [1:0]      exp_start, exp_coin;
    logic            exp_pause;
    logic [63:0]     exp_dip;
    logic [3:0]      exp_game;

    arcade_input_ctrl #(
        .NUM_PLAYERS (NP),
        .NUM_DIPS    (8),
        .DIP_INDEX   (254),
        .GAME_INDEX  (1),
        .COIN_PULSE  (CP),
        .AUTOFIRE_DIV(AD)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ps2_key    (ps2_key),
        .joystick   (joystick),
        .autofire_en(autofire_en),
        .ioctl_wr   (ioctl_wr),
        .ioctl_index(ioctl_index),
        .ioctl_addr (ioctl_addr),
        .ioctl_data (ioctl_data),
        .dir        (dir),
        .btn        (btn),
        .start      (start),
        .coin       (coin),
        .pause      (pause),
        .dip        (dip),
        .game_index (game_index)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_key = '0; m_tog = 1'b0; m_cyc = 0;
        m_hi[0] = 0; m_hi[1] = 0;
        m_wait = '0; m_cprev = '0; m_pprev = 1'b0;
        exp_dir = '0; exp_btn = '0; exp_start = '0; exp_coin = '0;
        exp_pause = 1'b0; exp_dip = '0; exp_game = '0;
    endtask

    task automatic check_all();
        chk("dir", 64'(dir), 64'(exp_dir));
        chk("btn", 64'(btn), 64'(exp_btn));
        chk("start", 64'(start), 64'(exp_start));
        chk("coin", 64'(coin), 64'(exp_coin));
        chk("pause", 64'(pause), 64'(exp_pause));
        chk("dip", dip, exp_dip);
        chk("game_index", 64'(game_index), 64'(exp_game));
    endtask

    // One clock: predict the registered outputs from the present inputs, then compare.
    task automatic step();
        logic [1:0][9:0] mj;
        logic            phase, any_p;
        phase = ((m_cyc / AD) % 2) == 1;
        any_p = 1'b0;
        for (int p = 0; p < NP; p++) begin
            mj[p] = m_key[p] | joystick[32*p +: 10];
            exp_dir[4*p +: 4] = {mj[p][3], mj[p][2], mj[p][0], mj[p][1]};
            exp_btn[3*p +: 3] = {mj[p][6], mj[p][5], mj[p][4] & (autofire_en[p] ? phase : 1'b1)};
            exp_start[p] = mj[p][7];
            any_p = any_p | mj[p][9];
            if (m_hi[p] > 0) begin
                m_hi[p]--;
                if (m_hi[p] == 0) m_wait[p] = 1'b1;
            end else if (m_wait[p]) begin
                if (!mj[p][8]) m_wait[p] = 1'b0;
            end else if (mj[p][8] && !m_cprev[p]) begin
                m_hi[p] = CP;
            end
            exp_coin[p] = m_hi[p] > 0;
            m_cprev[p] = mj[p][8];
        end
        if (any_p && !m_pprev) exp_pause = ~exp_pause;
        m_pprev = any_p;
        if (ioctl_wr && ioctl_index == 16'd254 && ioctl_addr < 27'd8)
            exp_dip[ioctl_addr[2:0]*8 +: 8] = ioctl_data;
        if (ioctl_wr && ioctl_index == 16'd1) exp_game = ioctl_data[3:0];
        if (ps2_key[10] != m_tog) begin
            for (int p = 0; p < NP; p++)
                for (int b = 0; b < 10; b++)
                    if (KEYMAP[p][b] != 9'h000 && KEYMAP[p][b] == ps2_key[8:0])
                        m_key[p][b] = ps2_key[9];
        end
        m_tog = ps2_key[10];
        m_cyc++;
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        reset_n = 1'b1;
    endtask

    initial begin
        int       n;
        logic [8:0] code;
        #1;
        do_reset();

        // Extended up-arrow press then release: two-cycle latency each way.
        ps2_key = {1'b1, 1'b1, 1'b1, 8'h75};
        step();
        chk("key_up_lat1", 64'(dir[3]), 64'd0);
        step();
        chk("key_up_press", 64'(dir[3]), 64'd1);
        ps2_key = {1'b0, 1'b0, 1'b1, 8'h75};
        step();
        step();
        chk("key_up_release", 64'(dir[3]), 64'd0);

        // Held coin gives exactly one pulse of CP cycles.
        joystick[8] = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (coin[0] === 1'b1) n++;
        end
        chk("coin_width", 64'(n), 64'(CP));
        joystick[8] = 1'b0;
        step();
        step();
        joystick[8] = 1'b1;
        step();
        chk("coin_repress", 64'(coin[0]), 64'd1);
        joystick[8] = 1'b0;
        repeat (6) step();

        // Autofire on player 1: half the cycles of any 12-cycle window are high.
        autofire_en = 2'b10;
        joystick[36] = 1'b1;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (btn[3] === 1'b1) n++;
        end
        chk("autofire_duty", 64'(n), 64'd6);
        autofire_en = 2'b00;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (btn[3] === 1'b1) n++;
        end
        chk("autofire_off", 64'(n), 64'd6);
        joystick[36] = 1'b0;
        step();

        // DIP downloads at addresses 0..9; the last two fall outside the bank.
        for (int a = 0; a < 10; a++) begin
            ioctl_wr = 1'b1; ioctl_index = 16'd254;
            ioctl_addr = 27'(a); ioctl_data = 8'(8'hA0 + a);
            step();
        end
        ioctl_wr = 1'b0;
        step();
        chk("dip_bank", dip, 64'hA7A6_A5A4_A3A2_A1A0);

        // Pause from player 0 then player 1.
        joystick[9] = 1'b1;  step();
        chk("pause_on", 64'(pause), 64'd1);
        joystick[9] = 1'b0;  step();
        joystick[41] = 1'b1; step();
        chk("pause_off", 64'(pause), 64'd0);
        joystick[41] = 1'b0; step();

        ioctl_wr = 1'b1; ioctl_index = 16'd1; ioctl_addr = '0; ioctl_data = 8'h13;
        step();
        ioctl_wr = 1'b0;
        chk("game_index", 64'(game_index), 64'd3);

        // Randomized traffic on every input.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(2) == 0) begin
                if ($urandom_range(7) == 0) code = 9'($urandom_range(511));
                else code = KEYMAP[$urandom_range(3)][$urandom_range(9)];
                ps2_key = {~ps2_key[10], 1'($urandom_range(1)), code};
            end
            if ($urandom_range(3) == 0) begin
                n = 32 * $urandom_range(1) + $urandom_range(9);
                joystick[n] = ~joystick[n];
            end
            if ($urandom_range(15) == 0) autofire_en = 2'($urandom_range(3));
            ioctl_wr = ($urandom_range(3) == 0);
            case ($urandom_range(2))
                0: ioctl_index = 16'd254;
                1: ioctl_index = 16'd1;
                default: ioctl_index = 16'd7;
            endcase
            ioctl_addr = 27'($urandom_range(11));
            ioctl_data = 8'($urandom_range(255));
            step();
        end
        ioctl_wr = 1'b0;

        // Clear any key-held coin, then reset in the middle of a fresh pulse.
        ps2_key = {~ps2_key[10], 1'b0, KEYMAP[0][8]};
        step();
        ps2_key = {~ps2_key[10], 1'b0, KEYMAP[1][8]};
        step();
        joystick = '0;
        repeat (8) step();
        joystick[8] = 1'b1;
        step();
        step();
        chk("coin_before_rst", 64'(coin[0]), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("coin_async_rst", 64'(coin[0]), 64'd0);
        chk("dip_async_rst", dip, 64'd0);
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        reset_n = 1'b1;
        repeat (8) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
